// File: rtl/fetch_sequencer_pkg.sv
// Shared CPU package: stage encodings, the sequencer's internal state type,
// the reset PC default and the instruction width.
// Ports: none (package).
package fetch_sequencer_pkg;

  localparam int unsigned INSTR_W          = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Externally visible pipeline stage, also decoded by the branch unit.
  typedef enum logic [1:0] {
    STAGE_FETCH     = 2'b00,
    STAGE_EXECUTE   = 2'b01,
    STAGE_MEMORY    = 2'b10,
    STAGE_WRITEBACK = 2'b11
  } stage_t;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_EXECUTE,
    ST_MEMORY,
    ST_WRITEBACK,
    ST_HALTED
  } state_t;

  // HALTED reports the fetch encoding; the halted flag distinguishes it.
  function automatic stage_t stage_of(input state_t s);
    case (s)
      ST_EXECUTE:   return STAGE_EXECUTE;
      ST_MEMORY:    return STAGE_MEMORY;
      ST_WRITEBACK: return STAGE_WRITEBACK;
      default:      return STAGE_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory read handshake between the fetch sequencer and memory.
// Signals: req/addr (sequencer -> memory), ready/rdata (memory -> sequencer).
// Modports: master (sequencer side), slave (memory side).
interface fetch_sequencer_if;
  import fetch_sequencer_pkg::*;

  logic               req;
  logic [31:0]        addr;
  logic               ready;
  logic [INSTR_W-1:0] rdata;

  modport master (output req, addr, input ready, rdata);
  modport slave  (input req, addr, output ready, rdata);
endinterface

// File: rtl/fetch_sequencer_next_pc_calc.sv
// Next-PC adder/mux: taken branch adds the signed offset, otherwise PC_STEP.
// Addition is plain 32-bit, so the PC wraps modulo 2^32.
// Ports: pc, branch_enable, branch_offset (in); target (out).
module next_pc_calc #(
  parameter int unsigned PC_STEP = 4
) (
  input  logic [31:0] pc,
  input  logic        branch_enable,
  input  logic [31:0] branch_offset,
  output logic [31:0] target
);

  assign target = branch_enable ? (pc + branch_offset) : (pc + 32'(PC_STEP));

endmodule

// File: rtl/fetch_sequencer.sv
// Four-stage instruction fetch sequencer with halt and misalignment trap.
// Ports: clk, rst_n (async, active-low); branch_enable/branch_offset (taken
// branch, used in EXECUTE only); halt_req (checked in WRITEBACK only);
// imem (master side of the instruction-memory handshake); stage, pc,
// instruction, retire, halted, misalign_trap (status outputs).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// FETCH     | request imem at pc, wait for ready, capture instruction
// EXECUTE   | compute next_pc (branch target or sequential)
// MEMORY    | single pass-through cycle
// WRITEBACK | retire pulse, pc <= next_pc, choose FETCH or HALTED
// HALTED    | terminal until reset, all inputs ignored
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               branch_enable,
  input  logic [31:0]        branch_offset,
  input  logic               halt_req,
  fetch_sequencer_if.master  imem,
  output logic [1:0]         stage,
  output logic [31:0]        pc,
  output logic [INSTR_W-1:0] instruction,
  output logic               retire,
  output logic               halted,
  output logic               misalign_trap
);

  state_t      state_q, state_d;
  logic [31:0] next_pc_q;
  logic [31:0] pc_target;
  logic        fetch_req;

  next_pc_calc #(.PC_STEP(PC_STEP)) u_next_pc_calc (
    .pc            (pc),
    .branch_enable (branch_enable),
    .branch_offset (branch_offset),
    .target        (pc_target)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_FETCH;
      pc            <= RESET_PC;
      next_pc_q     <= RESET_PC;
      instruction   <= '0;
      misalign_trap <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_FETCH:     if (imem.ready) instruction <= imem.rdata;
        ST_EXECUTE:   next_pc_q <= pc_target;
        ST_WRITEBACK: begin
          pc <= next_pc_q;
          if (next_pc_q[1:0] != 2'b00) misalign_trap <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    fetch_req = 1'b0;
    retire    = 1'b0;
    halted    = 1'b0;
    case (state_q)
      ST_FETCH: begin
        fetch_req = 1'b1;
        if (imem.ready) state_d = ST_EXECUTE;
      end
      ST_EXECUTE: state_d = ST_MEMORY;
      ST_MEMORY:  state_d = ST_WRITEBACK;
      ST_WRITEBACK: begin
        retire = 1'b1;
        if (next_pc_q[1:0] != 2'b00) state_d = ST_HALTED;
        else if (halt_req)           state_d = ST_HALTED;
        else                         state_d = ST_FETCH;
      end
      ST_HALTED: halted = 1'b1;
      default:   state_d = ST_FETCH;
    endcase
  end

  // The state register already sits in FETCH while reset is held, so the
  // request is masked by rst_n to keep it low until reset is released.
  assign imem.req  = fetch_req & rst_n;
  assign imem.addr = pc;
  assign stage     = stage_of(state_q);

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        branch_enable;
  logic [31:0] branch_offset;
  logic        halt_req;
  logic [1:0]  stage;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        retire;
  logic        halted;
  logic        misalign_trap;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_sequencer_if imem_bus ();

  fetch_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .branch_enable (branch_enable),
    .branch_offset (branch_offset),
    .halt_req      (halt_req),
    .imem          (imem_bus),
    .stage         (stage),
    .pc            (pc),
    .instruction   (instruction),
    .retire        (retire),
    .halted        (halted),
    .misalign_trap (misalign_trap)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Starts in FETCH with ready high; leaves the sequencer just after WRITEBACK.
  task automatic run_instr(input logic br, input logic [31:0] off);
    step();
    branch_enable = br;
    branch_offset = off;
    step();
    branch_enable = 1'b0;
    branch_offset = 32'h0;
    step();
    check("run_retire", 32'(retire), 32'd1);
    step();
  endtask

  initial begin
    rst_n         = 1'b0;
    branch_enable = 1'b0;
    branch_offset = 32'h0;
    halt_req      = 1'b0;
    imem_bus.ready = 1'b1;
    imem_bus.rdata = 32'h0000_0013;

    @(negedge clk);
    check("rst_stage",    32'(stage),         32'd0);
    check("rst_pc",       pc,                 32'h0);
    check("rst_req",      32'(imem_bus.req),  32'd0);
    check("rst_retire",   32'(retire),        32'd0);
    check("rst_halted",   32'(halted),        32'd0);
    check("rst_misalign", 32'(misalign_trap), 32'd0);
    check("rst_instr",    instruction,        32'h0);

    rst_n = 1'b1;
    #1;
    check("first_req",  32'(imem_bus.req), 32'd1);
    check("first_addr", imem_bus.addr,     32'h0);

    // Back-to-back sequential instructions: retire every 4th cycle, pc 0,4,8.
    for (int k = 1; k <= 12; k++) begin
      step();
      check("seq_stage",  32'(stage),  32'(k % 4));
      check("seq_retire", 32'(retire), (k % 4 == 3) ? 32'd1 : 32'd0);
      if (k % 4 == 3) check("seq_pc", pc, 32'((k / 4) * 4));
      if (k == 1) check("seq_instr", instruction, 32'h0000_0013);
    end
    check("seq_end_pc",    pc,          32'd12);
    check("seq_end_stage", 32'(stage),  32'd0);

    // Three wait cycles in FETCH; branch inputs outside EXECUTE must be ignored.
    imem_bus.ready = 1'b0;
    imem_bus.rdata = 32'hABCD_0001;
    branch_enable  = 1'b1;
    branch_offset  = 32'h0000_0100;
    for (int i = 0; i < 3; i++) begin
      step();
      check("wait_stage",  32'(stage),        32'd0);
      check("wait_req",    32'(imem_bus.req), 32'd1);
      check("wait_addr",   imem_bus.addr,     32'd12);
      check("wait_retire", 32'(retire),       32'd0);
      check("wait_instr",  instruction,       32'h0000_0013);
    end
    imem_bus.ready = 1'b1;
    step();
    branch_enable = 1'b0;
    check("wait_exe_stage", 32'(stage),        32'd1);
    check("wait_exe_instr", instruction,       32'hABCD_0001);
    check("wait_exe_req",   32'(imem_bus.req), 32'd0);
    check("wait_exe_addr",  imem_bus.addr,     32'd12);
    step();
    // MEMORY: stray branch and a halt pulse that is gone by WRITEBACK.
    branch_enable  = 1'b1;
    halt_req       = 1'b1;
    imem_bus.rdata = 32'hDEAD_BEEF;
    check("mem_instr_hold", instruction, 32'hABCD_0001);
    step();
    halt_req      = 1'b0;
    branch_enable = 1'b0;
    check("wait_retire7", 32'(retire), 32'd1);
    check("wait_wb_pc",   pc,          32'd12);
    step();
    check("pulse_no_halt", 32'(halted), 32'd0);
    check("pulse_stage",   32'(stage),  32'd0);
    check("ignored_br_pc", pc,          32'd16);

    // Backward branch at pc 0x10 with offset -8.
    imem_bus.rdata = 32'h1111_2222;
    run_instr(1'b1, 32'hFFFF_FFF8);
    check("br_back_pc",    pc,          32'h0000_0008);
    check("br_back_instr", instruction, 32'h1111_2222);

    // Reset asserted in MEMORY.
    step();
    step();
    check("pre_rst_stage", 32'(stage), 32'd2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_pc",     pc,                32'h0);
    check("mid_rst_stage",  32'(stage),        32'd0);
    check("mid_rst_retire", 32'(retire),       32'd0);
    check("mid_rst_req",    32'(imem_bus.req), 32'd0);
    check("mid_rst_instr",  instruction,       32'h0);
    @(negedge clk);
    check("mid_rst_noret", 32'(retire), 32'd0);
    rst_n = 1'b1;

    // Halt request held from MEMORY through WRITEBACK.
    step();
    step();
    halt_req = 1'b1;
    step();
    check("halt_wb_retire", 32'(retire), 32'd1);
    check("halt_wb_halted", 32'(halted), 32'd0);
    step();
    check("halt_halted", 32'(halted),        32'd1);
    check("halt_stage",  32'(stage),         32'd0);
    check("halt_req",    32'(imem_bus.req),  32'd0);
    check("halt_pc",     pc,                 32'd4);
    halt_req      = 1'b0;
    branch_enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("halt_stay",     32'(halted),       32'd1);
      check("halt_stay_req", 32'(imem_bus.req), 32'd0);
      check("halt_stay_pc",  pc,                32'd4);
      check("halt_stay_ret", 32'(retire),       32'd0);
    end
    branch_enable = 1'b0;

    rst_n = 1'b0;
    @(negedge clk);
    check("rst2_halted", 32'(halted), 32'd0);
    rst_n = 1'b1;

    // 32-bit wrap: 0 -> FFFF_FFFC via branch, then +4 wraps to 0.
    run_instr(1'b1, 32'hFFFF_FFFC);
    check("wrap_top_pc", pc, 32'hFFFF_FFFC);
    run_instr(1'b0, 32'h0);
    check("wrap_zero_pc", pc, 32'h0);

    // Misaligned target: 0x20 + 6.
    run_instr(1'b1, 32'h0000_0020);
    check("mis_pre_pc",  pc,                 32'h0000_0020);
    check("mis_pre_flag", 32'(misalign_trap), 32'd0);
    run_instr(1'b1, 32'h0000_0006);
    check("mis_pc",     pc,                 32'h0000_0026);
    check("mis_flag",   32'(misalign_trap), 32'd1);
    check("mis_halted", 32'(halted),        32'd1);
    check("mis_req",    32'(imem_bus.req),  32'd0);
    step();
    step();
    check("mis_req_later",  32'(imem_bus.req),  32'd0);
    check("mis_flag_later", 32'(misalign_trap), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
